// File: rtl/vertex_pkg.sv
// Shared types and constants for the vertex feed front end: cfg address map,
// 16.16 fixed-point helpers and the feed FSM state encoding.
package vertex_pkg;

  typedef logic signed [31:0] fix16_t;

  localparam logic [4:0] CFG_MAT0   = 5'd0;
  localparam logic [4:0] CFG_LIGHT0 = 5'd16;
  localparam logic [4:0] CFG_BASE   = 5'd19;
  localparam logic [4:0] CFG_COUNT  = 5'd20;
  localparam logic [4:0] CFG_CTRL   = 5'd21;

  localparam fix16_t FIX_ONE = 32'sh0001_0000;

  localparam int NUM_V   = 15;
  localparam int NUM_COL = 3;

  // Element [2] is the z component, so the default light points down +z.
  localparam logic [2:0][31:0] LIGHT_RST = {FIX_ONE, 32'd0, 32'd0};

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT,
    S_DONE
  } feed_state_t;

  function automatic logic [15:0][31:0] ident_mat();
    logic [15:0][31:0] m;
    m     = '0;
    m[0]  = FIX_ONE;
    m[5]  = FIX_ONE;
    m[10] = FIX_ONE;
    m[15] = FIX_ONE;
    return m;
  endfunction

endpackage

// File: rtl/vertex_feed_ctrl_if.sv
// Memory read port and triangle output handshake of the vertex feed block.
interface vertex_feed_ctrl_if;
  import vertex_pkg::*;

  logic                   mem_req;
  logic [31:0]            mem_addr;
  logic                   mem_rvalid;
  logic [31:0]            mem_rdata;
  logic [NUM_V-1:0][31:0] v_out;
  logic [23:0]            color_out1;
  logic [23:0]            color_out2;
  logic [23:0]            color_out3;
  logic                   tri_valid;
  logic                   tri_done;
  logic                   tri_stall;

  modport master (
    output mem_req, mem_addr,
    input  mem_rvalid, mem_rdata,
    output v_out, color_out1, color_out2, color_out3, tri_valid, tri_done,
    input  tri_stall
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_rvalid, mem_rdata,
    input  v_out, color_out1, color_out2, color_out3, tri_valid, tri_done,
    output tri_stall
  );

endinterface

// File: rtl/vertex_cfg_regs.sv
// Host register file: transform matrix, light vector, frame base/count.
// All writes and the start decode are locked out while the feed is busy.
module vertex_cfg_regs
  import vertex_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [4:0]             cfg_addr,
  input  logic [31:0]            cfg_wdata,
  input  logic                   busy,
  output logic [15:0][31:0]      mat,
  output logic [2:0][31:0]       lighting,
  output logic [31:0]            base,
  output logic [CNT_W-1:0]       count,
  output logic                   start
);

  logic [15:0][31:0] mat_q, mat_d;
  logic [2:0][31:0]  light_q, light_d;
  logic [31:0]       base_q, base_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr;

  always_comb begin
    mat_d   = mat_q;
    light_d = light_q;
    base_d  = base_q;
    count_d = count_q;
    wr      = cfg_we && !busy;
    if (wr) begin
      if (cfg_addr < CFG_LIGHT0)       mat_d[cfg_addr[3:0]]   = cfg_wdata;
      else if (cfg_addr < CFG_BASE)    light_d[cfg_addr[1:0]] = cfg_wdata;
      else if (cfg_addr == CFG_BASE)   base_d  = cfg_wdata;
      else if (cfg_addr == CFG_COUNT)  count_d = cfg_wdata[CNT_W-1:0];
    end
    start = wr && (cfg_addr == CFG_CTRL) && cfg_wdata[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mat_q   <= ident_mat();
      light_q <= LIGHT_RST;
      base_q  <= '0;
      count_q <= '0;
    end else begin
      mat_q   <= mat_d;
      light_q <= light_d;
      base_q  <= base_d;
      count_q <= count_d;
    end
  end

  assign mat      = mat_q;
  assign lighting = light_q;
  assign base     = base_q;
  assign count    = count_q;

endmodule

// File: rtl/vertex_feed_ctrl.sv
// Vertex feed scheduler: fetches triangle records one word at a time into a
// staging buffer and presents each triangle downstream with valid/stall.
module vertex_feed_ctrl
  import vertex_pkg::*;
#(
  parameter int REC_WORDS = 18,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [4:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0][31:0] mat,
  output logic [2:0][31:0]  lighting,
  vertex_feed_ctrl_if.master vf
);

  localparam int WW = $clog2(REC_WORDS);

  logic [31:0]      base;
  logic [CNT_W-1:0] count;
  logic             start;

  feed_state_t            state_q, state_d;
  logic [31:0]            ptr_q, ptr_d;
  logic [WW-1:0]          word_q, word_d;
  logic [CNT_W-1:0]       tri_idx_q, tri_idx_d;
  logic                   outst_q, outst_d;
  logic [NUM_V-1:0][31:0] v_q, v_d;
  logic [NUM_COL-1:0][23:0] col_q, col_d;
  logic                   mem_req;
  logic                   last_tri;
  logic                   rd_ok;

  vertex_cfg_regs #(.CNT_W(CNT_W)) u_cfg (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .busy      (busy),
    .mat       (mat),
    .lighting  (lighting),
    .base      (base),
    .count     (count),
    .start     (start)
  );

  assign last_tri = (tri_idx_q == count - CNT_W'(1));
  // Data beats with nothing outstanding (e.g. from before a reset) are dropped.
  assign rd_ok    = vf.mem_rvalid && outst_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    word_d     = word_q;
    tri_idx_d  = tri_idx_q;
    outst_d    = outst_q;
    v_d        = v_q;
    col_d      = col_q;
    mem_req    = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d     = base;
          tri_idx_d = '0;
          word_d    = '0;
          outst_d   = 1'b0;
          state_d   = (count == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        mem_req = !outst_q;
        if (mem_req) outst_d = 1'b1;
        if (rd_ok) begin
          for (int i = 0; i < NUM_V; i++)
            if (word_q == WW'(i)) v_d[i] = vf.mem_rdata;
          for (int i = 0; i < NUM_COL; i++)
            if (word_q == WW'(NUM_V + i)) col_d[i] = vf.mem_rdata[23:0];
          ptr_d   = ptr_q + 32'd4;
          outst_d = 1'b0;
          if (word_q == WW'(REC_WORDS - 1)) begin
            word_d  = '0;
            state_d = S_PRESENT;
          end else begin
            word_d  = word_q + WW'(1);
          end
        end
      end
      S_PRESENT: begin
        if (!vf.tri_stall) begin
          tri_idx_d = tri_idx_q + CNT_W'(1);
          state_d   = last_tri ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      word_q    <= '0;
      tri_idx_q <= '0;
      outst_q   <= 1'b0;
      v_q       <= '0;
      col_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      word_q    <= word_d;
      tri_idx_q <= tri_idx_d;
      outst_q   <= outst_d;
      v_q       <= v_d;
      col_q     <= col_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign vf.mem_req    = mem_req;
  assign vf.mem_addr   = ptr_q;
  assign vf.v_out      = v_q;
  assign vf.color_out1 = col_q[0];
  assign vf.color_out2 = col_q[1];
  assign vf.color_out3 = col_q[2];
  assign vf.tri_valid  = (state_q == S_PRESENT);
  assign vf.tri_done   = (state_q == S_PRESENT) && last_tri;

endmodule

// File: tb/tb_vertex_feed_ctrl.sv
// Directed bench for vertex_feed_ctrl: a frame-level scoreboard model checks
// every cycle, plus hand-computed literal expectations per scenario.
module tb_vertex_feed_ctrl;
  import vertex_pkg::*;

  logic              clk, rst_n, cfg_we;
  logic [4:0]        cfg_addr;
  logic [31:0]       cfg_wdata;
  logic              busy, frame_done;
  logic [15:0][31:0] mat;
  logic [2:0][31:0]  lighting;

  vertex_feed_ctrl_if vif();

  vertex_feed_ctrl #(.REC_WORDS(18), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .busy      (busy),
    .frame_done(frame_done),
    .mat       (mat),
    .lighting  (lighting),
    .vf        (vif.master)
  );

  int tests = 0, fails = 0, cyc = 0, lat = 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Memory: one read slot, returns mem_word(addr) exactly lat cycles after req.
  int          pend_cnt = 0;
  logic [31:0] pend_addr;
  initial begin
    vif.mem_rvalid = 0;
    vif.mem_rdata  = 0;
    forever begin
      @(posedge clk);
      #1;
      vif.mem_rvalid = 0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          vif.mem_rvalid = 1;
          vif.mem_rdata  = mem_word(pend_addr);
        end
      end
      #1;
      if (vif.mem_req) begin
        pend_cnt  = lat;
        pend_addr = vif.mem_addr;
      end
    end
  end

  // Frame-level model: what the next cycle must show (0 nothing, 1 req, 2 tri, 3 done).
  logic [15:0][31:0] m_mat;
  logic [2:0][31:0]  m_light;
  logic [31:0]       m_base;
  int   m_count, exp_ev, words, tri_k, req_n, fd_cnt, busy_cyc, stall_cnt, stale_cnt = 0;
  int   first_req_cyc, first_tv_cyc;
  bit   active, outst;
  logic first_td;
  logic [31:0] first_v0;
  logic [31:0] addr_log[$];

  task automatic model_reset();
    m_mat = '0;
    for (int i = 0; i < 4; i++) m_mat[i*5] = 32'h0001_0000;
    m_light    = '0;
    m_light[2] = 32'h0001_0000;
    m_base = 0; m_count = 0; exp_ev = 0; active = 0; outst = 0;
  endtask

  always @(negedge clk) begin : cmp
    int nxt;
    logic [31:0] ea, w;
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_mem_req", vif.mem_req, 0);
      chk("rst_tri_valid", vif.tri_valid, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_v_out0", vif.v_out[0], 0);
      chk("rst_color3", vif.color_out3, 0);
      model_reset();
    end else begin
      nxt = 0;
      chk("busy", busy, active);
      chk("mem_req", vif.mem_req, exp_ev == 1);
      chk("tri_valid", vif.tri_valid, exp_ev == 2);
      chk("frame_done", frame_done, exp_ev == 3);
      for (int i = 0; i < 16; i++) chk($sformatf("mat[%0d]", i), mat[i], m_mat[i]);
      for (int i = 0; i < 3; i++) chk($sformatf("lighting[%0d]", i), lighting[i], m_light[i]);
      if (vif.mem_req) begin
        chk("mem_addr", vif.mem_addr, m_base + 32'(4 * req_n));
        if (req_n == 0) first_req_cyc = cyc;
        addr_log.push_back(vif.mem_addr);
        req_n++;
        outst = 1;
      end
      if (vif.tri_valid) begin
        ea = m_base + 32'(72 * tri_k);
        for (int i = 0; i < 15; i++)
          chk($sformatf("v_out[%0d]", i), vif.v_out[i], mem_word(ea + 32'(4 * i)));
        w = mem_word(ea + 32'd60); chk("color_out1", vif.color_out1, {8'h0, w[23:0]});
        w = mem_word(ea + 32'd64); chk("color_out2", vif.color_out2, {8'h0, w[23:0]});
        w = mem_word(ea + 32'd68); chk("color_out3", vif.color_out3, {8'h0, w[23:0]});
        chk("tri_done", vif.tri_done, tri_k == m_count - 1);
        if (first_tv_cyc < 0) begin
          first_tv_cyc = cyc; first_td = vif.tri_done; first_v0 = vif.v_out[0];
        end
        if (vif.tri_stall) begin
          stall_cnt++; nxt = 2;
        end else begin
          tri_k++; nxt = (tri_k == m_count) ? 3 : 1;
        end
      end
      if (vif.mem_rvalid) begin
        if (outst) begin
          outst = 0; words++; nxt = (words % 18 == 0) ? 2 : 1;
        end else stale_cnt++;
      end
      if (frame_done) fd_cnt++;
      if (busy) busy_cyc++;
      if (cfg_we && !active) begin
        if (cfg_addr < 16)       m_mat[cfg_addr[3:0]] = cfg_wdata;
        else if (cfg_addr < 19)  m_light[cfg_addr - 5'd16] = cfg_wdata;
        else if (cfg_addr == 19) m_base = cfg_wdata;
        else if (cfg_addr == 20) m_count = int'(cfg_wdata[15:0]);
        else if (cfg_addr == 21 && cfg_wdata[0]) begin
          active = 1; req_n = 0; words = 0; tri_k = 0; fd_cnt = 0; busy_cyc = 0;
          stall_cnt = 0; first_req_cyc = -1; first_tv_cyc = -1; addr_log.delete();
          nxt = (m_count == 0) ? 3 : 1;
        end
      end
      if (exp_ev == 3) active = 0;
      exp_ev = nxt;
    end
  end

  task automatic cfg_write(logic [4:0] a, logic [31:0] d);
    @(posedge clk); #1;
    cfg_we = 1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (fd_cnt == 0 && t < 2000) begin @(posedge clk); t++; end
    chk("frame_done_seen", fd_cnt > 0, 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    rst_n = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; vif.tri_stall = 0;
    repeat (2) @(negedge clk);
    chk("lit_mat0", mat[0], 32'h0001_0000);
    chk("lit_mat5", mat[5], 32'h0001_0000);
    chk("lit_mat10", mat[10], 32'h0001_0000);
    chk("lit_mat15", mat[15], 32'h0001_0000);
    chk("lit_mat1", mat[1], 0);
    chk("lit_mat14", mat[14], 0);
    chk("lit_light2", lighting[2], 32'h0001_0000);
    chk("lit_light0", lighting[0], 0);
    chk("lit_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1;

    // Two-triangle frame at 0x1000, latency 1.
    cfg_write(5'd3, 32'h1234_5678);
    chk("lit_mat3_wr", mat[3], 32'h1234_5678);
    cfg_write(5'd19, 32'h1000);
    cfg_write(5'd20, 2);
    cfg_write(5'd21, 1);
    wait_done();
    chk("lit_nreq", addr_log.size(), 36);
    chk("lit_addr0", addr_log[0], 32'h1000);
    chk("lit_addr17", addr_log[17], 32'h1044);
    chk("lit_addr18", addr_log[18], 32'h1048);
    chk("lit_addr35", addr_log[35], 32'h108C);
    chk("lit_tv_latency", first_tv_cyc - first_req_cyc, 36);
    chk("lit_first_done", first_td, 0);
    chk("lit_v0", first_v0, 32'hC0DE_1000);
    chk("lit_fd_once", fd_cnt, 1);

    // Stall the first triangle for 5 cycles.
    vif.tri_stall = 1;
    cfg_write(5'd19, 32'h2000);
    cfg_write(5'd21, 1);
    t = 0;
    while (!vif.tri_valid && t < 500) begin @(posedge clk); #1; t++; end
    chk("stall_tv_seen", vif.tri_valid, 1);
    repeat (5) @(posedge clk);
    #1 vif.tri_stall = 0;
    wait_done();
    chk("lit_stall_cycles", stall_cnt, 5);
    chk("lit_stall_nreq", addr_log.size(), 36);
    chk("lit_stall_fd", fd_cnt, 1);

    // Empty frame.
    cfg_write(5'd20, 0);
    cfg_write(5'd21, 1);
    wait_done();
    chk("lit_zero_busy", busy_cyc, 1);
    chk("lit_zero_nreq", addr_log.size(), 0);
    chk("lit_zero_fd", fd_cnt, 1);

    // Writes and a second start while busy are ignored.
    cfg_write(5'd19, 32'h3000);
    cfg_write(5'd20, 1);
    cfg_write(5'd21, 1);
    repeat (5) @(posedge clk);
    cfg_write(5'd3, 32'h5);
    cfg_write(5'd21, 1);
    wait_done();
    repeat (20) @(posedge clk);
    chk("lit_locked_mat3", mat[3], 32'h1234_5678);
    chk("lit_locked_fd", fd_cnt, 1);

    // Reset mid-fetch at word 7 with latency 3, then restart.
    lat = 3;
    cfg_write(5'd19, 32'h4000);
    cfg_write(5'd21, 1);
    t = 0;
    while (req_n < 8 && t < 500) begin @(posedge clk); t++; end
    chk("lit_reached_word7", addr_log[7], 32'h401C);
    #1 rst_n = 0;
    @(negedge clk);
    chk("lit_rst_busy", busy, 0);
    chk("lit_rst_mat3", mat[3], 0);
    @(posedge clk); #1 rst_n = 1;
    repeat (6) @(posedge clk);
    chk("lit_stale_seen", stale_cnt, 1);
    cfg_write(5'd19, 32'h4000);
    cfg_write(5'd20, 1);
    cfg_write(5'd21, 1);
    wait_done();
    chk("lit_restart_addr0", addr_log[0], 32'h4000);
    chk("lit_restart_nreq", addr_log.size(), 18);
    chk("lit_restart_fd", fd_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
